debouncer_bank: RTL and testbench
=================================

DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent button channels (legal range 2..16).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 50000, meaning the consecutive synchronized cycles an input must hold before acceptance (legal range ≥2).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop stages in each input synchronizer (legal range ≥2).
REQ-004 The block SHALL have a single clock and a synchronous active-high reset.
REQ-005 The ports SHALL be, in order:
- clk  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high.
- btn_in  in  N_CH  raw asynchronous button inputs.
- btn_level  out  N_CH  debounced level per channel.
- btn_press  out  N_CH  one-cycle pulse on each debounced rising edge.
- btn_release  out  N_CH  one-cycle pulse on each debounced falling edge.
- sel_onehot  out  N_CH  one-hot register holding the captured channel.
- sel_idx  out  clog2(N_CH)  binary encoding of sel_onehot.
- sel_valid  out  1  capture register holds an unacknowledged press.
- sel_ack  in  1  consumer acknowledge.
- overrun  out  1  sticky flag: a press event was dropped.

Function
REQ-006 Each btn_in bit SHALL pass through its own SYNC_STAGES-deep synchronizer before any other logic sees it.
REQ-007 Each channel SHALL run an independent four-state FSM: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-008 Each channel SHALL have its own counter, sized clog2(STABLE_CYCLES) bits.
REQ-009 In IDLE_LOW, a synchronized 1 SHALL move the channel to WAIT_HIGH with the counter set to 1.
REQ-010 In WAIT_HIGH, while the synchronized input is 1:
- the counter SHALL increment;
- when it equals STABLE_CYCLES-1, the channel SHALL go to IDLE_HIGH and clear the counter;
- a synchronized 0 SHALL return the channel to IDLE_LOW with the counter cleared.
REQ-011 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-009/REQ-010 with input polarity inverted, returning to IDLE_LOW on acceptance.
REQ-012 btn_level SHALL be 1 exactly in IDLE_HIGH and WAIT_LOW.
REQ-013 A clean input edge SHALL reach btn_level SYNC_STAGES+STABLE_CYCLES clock edges after the first sampling edge.
REQ-014 btn_press[i] SHALL be 1 for exactly the first cycle btn_level[i] is 1, registered together with btn_level.
REQ-015 btn_release[i] SHALL be 1 for exactly the first cycle btn_level[i] is 0.
REQ-016 Capture rules, with P = the btn_press vector:
- If sel_valid=0, or sel_valid=1 with sel_ack=1, and P≠0: the lowest-index set bit of P SHALL be loaded into sel_onehot, and sel_valid=1 on the next cycle.
- If sel_valid=1, sel_ack=1 and P=0: sel_valid, sel_onehot and sel_idx SHALL clear on the next cycle.
- If sel_valid=1, sel_ack=0 and P≠0: the capture register SHALL be unchanged, and overrun SHALL set.
REQ-017 If P has more than one bit set when a capture occurs, overrun SHALL set.
REQ-018 overrun SHALL clear on any cycle where sel_ack=1 and no new drop occurs that cycle; set wins over clear.
REQ-019 sel_idx SHALL be the binary index of the set bit of sel_onehot, and 0 when sel_onehot=0.
REQ-020 sel_ack while sel_valid=0 SHALL have no effect except clearing overrun.
REQ-021 sel_onehot SHALL never have more than one bit set.

Reset
REQ-022 While reset=1 at a clock edge:
- all synchronizers, counters and outputs SHALL be 0;
- all FSMs SHALL go to IDLE_LOW;
- the reset SHALL take effect mid-WAIT without producing any pulse.
REQ-023 An input held high through reset deassertion SHALL be debounced afresh and SHALL produce a btn_press.

Verification (N_CH=4, STABLE_CYCLES=4, SYNC_STAGES=2)
REQ-024 The bench SHALL cover the following directed scenarios:
- Clean press: btn_in=0001 held → btn_level[0]=1 and btn_press=0001 for one cycle, 6 edges after first sampling; sel_valid=1, sel_idx=0.
- Bounce: btn_in[2] toggling every 2 cycles for 20 cycles, then stable 1 → no pulse during the bounce; exactly one press afterwards; sel_idx=2.
- Simultaneous press: btn_in 0000→1010 in one cycle → sel_onehot=0010, sel_idx=1, overrun=1.
- Overrun and ack: press ch0, no ack, then press ch3 → sel_idx stays 0, overrun=1; then sel_ack=1 → sel_valid=0, overrun=0.
- Ack with same-cycle press: sel_ack=1 in the btn_press=1000 cycle → sel_valid stays 1, sel_idx=3, overrun=0.
- Reset mid-WAIT: reset pulsed 2 cycles into WAIT_HIGH → all outputs 0; with input still high after reset, a press occurs 6 edges later.

Source files
------------

// File: rtl/debouncer_bank.sv
// Bank of independent push-button debouncers. Each channel has an input synchronizer
// and a four-state hysteresis FSM, and new presses are captured into a one-hot register.
module debouncer_bank #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 50000,
  parameter int SYNC_STAGES   = 2,
  localparam int IDX_W        = $clog2(N_CH),
  localparam int CNT_W        = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  btn_in,
  output logic [N_CH-1:0]  btn_level,
  output logic [N_CH-1:0]  btn_press,
  output logic [N_CH-1:0]  btn_release,
  output logic [N_CH-1:0]  sel_onehot,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid,
  input  logic             sel_ack,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  s_in;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  press_d;
  logic [N_CH-1:0]  release_d;

  // The small synchronizer arrays are cleared too, so a mid-bounce reset leaves no
  // stale sample behind that could be accepted after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old
      // value; blocking ones would collapse the chain into a single flop.
      sync_q[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];

  // State register; the edge pulses are registered alongside so they align with btn_level.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE_LOW;
        cnt_q[i]   <= '0;
      end
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: hold-by-default first, so every path assigns state_d/cnt_d and no latch forms.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE_LOW: if (s_in[i]) begin
          state_d[i] = WAIT_HIGH;
          cnt_d[i]   = CNT_ONE;
        end
        WAIT_HIGH: begin
          if (!s_in[i]) begin
            state_d[i] = IDLE_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE_HIGH;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        IDLE_HIGH: if (!s_in[i]) begin
          state_d[i] = WAIT_LOW;
          cnt_d[i]   = CNT_ONE;
        end
        WAIT_LOW: begin
          if (s_in[i]) begin
            state_d[i] = IDLE_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE_LOW;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    btn_level = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      btn_level[i] = (state_q[i] == IDLE_HIGH) || (state_q[i] == WAIT_LOW);
      press_d[i]   = (state_q[i] == WAIT_HIGH) && (state_d[i] == IDLE_HIGH);
      release_d[i] = (state_q[i] == WAIT_LOW)  && (state_d[i] == IDLE_LOW);
    end
  end

  // Capture register: the lowest pressed channel wins; drops and multi-presses are flagged.
  logic [N_CH-1:0] p_low;
  logic            take;
  logic            drop;
  logic            multi;

  assign p_low = btn_press & (~btn_press + 1'b1);
  assign take  = (!sel_valid || sel_ack) && (|btn_press);
  assign drop  = sel_valid && !sel_ack && (|btn_press);
  assign multi = take && (|(btn_press & (btn_press - 1'b1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_onehot <= '0;
      sel_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take) begin
        sel_onehot <= p_low;
        sel_valid  <= 1'b1;
      end else if (sel_valid && sel_ack) begin
        sel_onehot <= '0;
        sel_valid  <= 1'b0;
      end
      if (drop || multi) overrun <= 1'b1;
      else if (sel_ack)  overrun <= 1'b0;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_onehot[i]) sel_idx = sel_idx | IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank (N_CH=4, STABLE_CYCLES=4, SYNC_STAGES=2): a
// cycle-by-cycle vector table for press/release, then hand-written corner sequences.
module tb_debouncer_bank;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] sel_onehot;
  logic [1:0]      sel_idx;
  logic            sel_valid;
  logic            sel_ack;
  logic            overrun;

  int n_total = 0;
  int n_pass  = 0;

  debouncer_bank #(.N_CH(N_CH), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .sel_onehot(sel_onehot),
    .sel_idx(sel_idx), .sel_valid(sel_valid), .sel_ack(sel_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       ack;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic       valid;
    logic [3:0] onehot;
    logic [1:0] idx;
    logic       ovr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until any press pulse appears; leaves the bench inside the pulse cycle.
  task automatic wait_press(input string name, input int budget);
    int seen;
    seen = 0;
    for (int k = 0; k < budget && seen == 0; k++) begin
      step();
      if (|btn_press) seen = 1;
    end
    check({name, "_press_seen"}, seen, 1);
  endtask

  task automatic ack_pulse();
    sel_ack = 1'b1;
    step();
    sel_ack = 1'b0;
  endtask

  initial begin
    int presses;
    int early;

    // Clean press on ch0 then release: 6 edges each way, capture on the 7th.
    for (int r = 0; r < 5; r++) vecs[r] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[5] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[6] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[7] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
    for (int r = 8; r < 13; r++) vecs[r] = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

    reset = 1'b1; btn_in = '0; sel_ack = 1'b0;
    idle(2);
    check("rst_level",   btn_level,  0);
    check("rst_press",   btn_press,  0);
    check("rst_release", btn_release, 0);
    check("rst_valid",   sel_valid,  0);
    check("rst_onehot",  sel_onehot, 0);
    check("rst_idx",     sel_idx,    0);
    check("rst_overrun", overrun,    0);
    reset = 1'b0;

    for (int r = 0; r < 17; r++) begin
      btn_in  = vecs[r].btn;
      sel_ack = vecs[r].ack;
      step();
      check($sformatf("v%0d_level", r),   btn_level,   vecs[r].level);
      check($sformatf("v%0d_press", r),   btn_press,   vecs[r].press);
      check($sformatf("v%0d_release", r), btn_release, vecs[r].rel);
      check($sformatf("v%0d_valid", r),   sel_valid,   vecs[r].valid);
      check($sformatf("v%0d_onehot", r),  sel_onehot,  vecs[r].onehot);
      check($sformatf("v%0d_idx", r),     sel_idx,     vecs[r].idx);
      check($sformatf("v%0d_overrun", r), overrun,     vecs[r].ovr);
    end
    sel_ack = 1'b0;

    // Bounce on ch2: high 2 cycles, low 2 cycles, for 20 cycles, then stable high.
    presses = 0;
    for (int k = 0; k < 20; k++) begin
      btn_in = {1'b0, ((k / 2) % 2 == 0), 2'b00};
      step();
      if (|btn_press || |btn_level) presses++;
    end
    check("bounce_no_pulse", presses, 0);
    btn_in = 4'b0100;
    presses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (btn_press == 4'b0100) presses++;
    end
    check("bounce_one_press", presses, 1);
    check("bounce_valid", sel_valid, 1);
    check("bounce_idx",   sel_idx,   2);
    ack_pulse();
    check("bounce_ack_valid", sel_valid, 0);
    btn_in = '0;
    idle(10);

    // Simultaneous press on ch1 and ch3.
    btn_in = 4'b1010;
    wait_press("simul", 12);
    check("simul_press", btn_press, 4'b1010);
    step();
    check("simul_onehot",  sel_onehot, 4'b0010);
    check("simul_idx",     sel_idx,    1);
    check("simul_overrun", overrun,    1);
    ack_pulse();
    check("simul_ack_valid",   sel_valid, 0);
    check("simul_ack_overrun", overrun,   0);
    btn_in = '0;
    idle(10);

    // Press ch0, leave it unacknowledged, then press ch3.
    btn_in = 4'b0001;
    wait_press("ovr0", 12);
    step();
    check("ovr0_idx", sel_idx, 0);
    btn_in = 4'b1001;
    wait_press("ovr3", 12);
    check("ovr3_press", btn_press, 4'b1000);
    step();
    check("ovr3_idx",     sel_idx,   0);
    check("ovr3_valid",   sel_valid, 1);
    check("ovr3_overrun", overrun,   1);
    ack_pulse();
    check("ovr_ack_valid",   sel_valid, 0);
    check("ovr_ack_overrun", overrun,   0);
    btn_in = '0;
    idle(10);

    // Acknowledge in the same cycle a new press on ch3 appears.
    btn_in = 4'b0010;
    wait_press("same1", 12);
    step();
    check("same1_idx", sel_idx, 1);
    btn_in = 4'b1010;
    wait_press("same3", 12);
    check("same3_press", btn_press, 4'b1000);
    sel_ack = 1'b1;
    step();
    sel_ack = 1'b0;
    check("same_valid",   sel_valid,  1);
    check("same_idx",     sel_idx,    3);
    check("same_onehot",  sel_onehot, 4'b1000);
    check("same_overrun", overrun,    0);
    btn_in = '0;
    idle(10);
    ack_pulse();

    // Reset two cycles into WAIT_HIGH with the input held high throughout.
    btn_in = 4'b0001;
    idle(4);
    reset = 1'b1;
    step();
    check("midrst_level",   btn_level,   0);
    check("midrst_press",   btn_press,   0);
    check("midrst_release", btn_release, 0);
    check("midrst_valid",   sel_valid,   0);
    check("midrst_onehot",  sel_onehot,  0);
    check("midrst_overrun", overrun,     0);
    reset = 1'b0;
    early = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (|btn_press || |btn_level) early++;
    end
    check("midrst_no_early", early, 0);
    step();
    check("midrst_press6", btn_press, 4'b0001);
    check("midrst_level6", btn_level, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
